// File: rtl/sgpr_pkg.sv
// sgpr_pkg: shared widths and types for the shadow register file
package sgpr_pkg;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS = 32;
  typedef logic [4:0] reg_addr_t;
  typedef logic [31:0] reg_data_t;
endpackage

// File: rtl/sgpr_wdec.sv
// sgpr_wdec: one-hot write-enable decode with optional masking of entry 0
module sgpr_wdec import sgpr_pkg::*; #(
  parameter int AW = ADDR_WIDTH,
  parameter bit ZERO_REG0 = 1'b1
) (
  input  logic [AW-1:0]    waddr,
  input  logic             we,
  output logic [2**AW-1:0] wen
);
  for (genvar i = 0; i < 2**AW; i++) begin : g_dec
    assign wen[i] = we && (waddr == AW'(i)) && !(ZERO_REG0 && i == 0);
  end
endmodule

// File: rtl/sgpr_regfile.sv
// sgpr_regfile: 2-read/1-write flop register file with optional hardwired-zero entry 0
module sgpr_regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter bit ZERO_REG0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  test_en_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic [DATA_WIDTH-1:0] wdata_a_i,
  input  logic                  we_a_i
);
  localparam int NR = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [NR];
  logic [NR-1:0] wen;
  logic unused_test_en;
  assign unused_test_en = test_en_i;
  sgpr_wdec #(.AW(ADDR_WIDTH), .ZERO_REG0(ZERO_REG0)) u_wdec (
    .waddr(waddr_a_i),
    .we   (we_a_i),
    .wen  (wen)
  );
  // rst_n is active-high despite its name; it clears the whole array asynchronously
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) mem <= '{default: '0};
    else for (int i = 0; i < NR; i++) if (wen[i]) mem[i] <= wdata_a_i;
  end
  assign rdata_a_o = (ZERO_REG0 && raddr_a_i == '0) ? '0 : mem[raddr_a_i];
  assign rdata_b_o = (ZERO_REG0 && raddr_b_i == '0) ? '0 : mem[raddr_b_i];
endmodule

// File: tb/tb_sgpr_regfile.sv
// tb_sgpr_regfile: randomized scoreboard bench for sgpr_regfile against an array model
module tb_sgpr_regfile;
  import sgpr_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, test_en_i = 1'b0, we_a_i = 1'b0;
  reg_addr_t raddr_a_i = '0, raddr_b_i = '0, waddr_a_i = '0;
  reg_data_t wdata_a_i = '0, rdata_a_o, rdata_b_o;
  typedef struct {string name; reg_data_t a; reg_data_t b;} exp_t;
  exp_t sb[$];
  reg_data_t model [NUM_REGS];
  int checks = 0, errors = 0;
  event sample;
  sgpr_regfile dut (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
    .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a_o),
    .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b_o),
    .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i), .we_a_i(we_a_i)
  );
  always #5 clk = ~clk;
  function automatic reg_data_t rd(input reg_addr_t x);
    return (x == 0) ? '0 : model[x];
  endfunction
  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask
  task automatic chk(input reg_addr_t ra, input reg_addr_t rb, input string nm);
    raddr_a_i = ra;
    raddr_b_i = rb;
    sb.push_back('{nm, rd(ra), rd(rb)});
    ->sample;
    #2;
  endtask
  task automatic wr(input reg_addr_t a, input reg_data_t d, input logic we);
    @(negedge clk);
    waddr_a_i = a;
    wdata_a_i = d;
    we_a_i = we;
    test_en_i = 1'($urandom);
    @(posedge clk);
    if (we && !rst_n && a != 0) model[a] = d;
    #1;
    we_a_i = 1'b0;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(sample);
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty got a=%h b=%h", rdata_a_o, rdata_b_o);
      end else begin
        e = sb.pop_front();
        if (rdata_a_o !== e.a || rdata_b_o !== e.b) begin
          errors++;
          $display("FAIL %s got a=%h b=%h want a=%h b=%h", e.name, rdata_a_o, rdata_b_o, e.a, e.b);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    clear_model();
    @(negedge clk);
    we_a_i = 1'b1;
    waddr_a_i = 5'd10;
    wdata_a_i = 32'd100;
    @(posedge clk);
    #2;
    chk(5'd10, 5'd11, "rst_blocks_wr");
    we_a_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    chk(5'd10, 5'd11, "rst_released");
    wr(5'd11, 32'd100, 1'b1);
    wr(5'd10, 32'd69, 1'b1);
    chk(5'd10, 5'd11, "basic_rw");
    wr(5'd11, 32'd133, 1'b0);
    chk(5'd11, 5'd11, "we_gate");
    wr(5'd11, 32'd133, 1'b1);
    chk(5'd11, 5'd10, "we_on");
    @(negedge clk);
    waddr_a_i = 5'd10;
    wdata_a_i = 32'hDEADBEEF;
    we_a_i = 1'b1;
    test_en_i = ~test_en_i;
    chk(5'd10, 5'd11, "collision_pre");
    @(posedge clk);
    model[10] = 32'hDEADBEEF;
    #1;
    we_a_i = 1'b0;
    chk(5'd10, 5'd10, "collision_post");
    wr(5'd0, 32'hFFFFFFFF, 1'b1);
    chk(5'd0, 5'd0, "zero_reg");
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      waddr_a_i = reg_addr_t'($urandom);
      wdata_a_i = $urandom;
      we_a_i = 1'($urandom);
      test_en_i = 1'($urandom);
      chk(reg_addr_t'($urandom), waddr_a_i, "rand_pre");
      @(posedge clk);
      if (we_a_i && waddr_a_i != 0) model[waddr_a_i] = wdata_a_i;
      #1;
      chk(waddr_a_i, reg_addr_t'($urandom), "rand_post");
    end
    for (int i = 1; i < NUM_REGS; i++) wr(reg_addr_t'(i), reg_data_t'(i), 1'b1);
    chk(5'd5, 5'd31, "fill");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
    chk(5'd5, 5'd31, "async_rst_now");
    for (int i = 0; i < NUM_REGS; i++) chk(reg_addr_t'(i), reg_addr_t'(31 - i), "rst_all");
    @(negedge clk);
    rst_n = 1'b0;
    wr(5'd7, 32'd7777, 1'b1);
    chk(5'd7, 5'd0, "post_rst_wr");
    #10;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
